// File: rtl/hazard_trap_ctrl.sv
// Decode-side pipeline sequencer: load-use interlock, branch flush, ECALL/MRET drain-and-redirect, stall counter.
// Controls are combinational from state and inputs (0-cycle); mem_busy freezes the whole pipe and this FSM.
module hazard_trap_ctrl #(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_is_ecall,
  input  logic             id_is_mret,
  input  logic             ex_valid,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_wr_reg_n,
  input  logic             ex_br_taken,
  input  logic             mem_busy,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             flush_id,
  output logic             flush_ex,
  output logic [1:0]       pc_sel,
  output logic             trap_we,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  localparam logic [1:0] PC_SEQ   = 2'b00;
  localparam logic [1:0] PC_BR    = 2'b01;
  localparam logic [1:0] PC_MTVEC = 2'b10;
  localparam logic [1:0] PC_MEPC  = 2'b11;

  localparam logic [3:0]       DRAIN_INIT = 4'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic             kind_q, kind_d;          // 1 = MRET, 0 = ECALL
  logic [3:0]       drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic load_use;
  logic id_trap;

  assign load_use = ex_valid & ex_is_load & ~ex_wr_reg_n & (ex_rd != 5'd0) & id_valid &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
  assign id_trap  = id_valid & (id_is_ecall | id_is_mret);

  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    drain_cnt_d = drain_cnt_q;
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    stall_ex    = 1'b0;
    flush_id    = 1'b0;
    flush_ex    = 1'b0;
    pc_sel      = PC_SEQ;
    trap_we     = 1'b0;

    if (mem_busy) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      stall_ex = 1'b1;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          // A taken branch makes everything younger in ID wrong-path, traps included.
          if (ex_br_taken) begin
            pc_sel   = PC_BR;
            flush_id = 1'b1;
            flush_ex = 1'b1;
          end else if (id_trap) begin
            stall_if    = 1'b1;
            stall_id    = 1'b1;
            flush_ex    = 1'b1;
            kind_d      = id_is_mret;
            drain_cnt_d = DRAIN_INIT;
            state_d     = (DRAIN_CYCLES > 1) ? ST_DRAIN : ST_REDIRECT;
          end else if (load_use) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            flush_ex = 1'b1;
          end
        end
        ST_DRAIN: begin
          stall_if    = 1'b1;
          stall_id    = 1'b1;
          flush_ex    = 1'b1;
          drain_cnt_d = (drain_cnt_q != 4'd0) ? drain_cnt_q - 4'd1 : 4'd0;
          if (drain_cnt_q <= 4'd1) begin
            state_d = ST_REDIRECT;
          end
        end
        ST_REDIRECT: begin
          flush_id = 1'b1;
          flush_ex = 1'b1;
          pc_sel   = kind_q ? PC_MEPC : PC_MTVEC;
          trap_we  = ~kind_q;
          state_d  = ST_RUN;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_if && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      kind_q      <= 1'b0;
      drain_cnt_q <= 4'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      drain_cnt_q <= drain_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign busy      = (state_q != ST_RUN);
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_trap_ctrl.sv
// Directed bench: default instance (DRAIN_CYCLES=2, CNT_W=32) plus a CNT_W=4 instance on the same inputs.
module tb_hazard_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_use_rs1, id_use_rs2, id_is_ecall, id_is_mret;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        ex_valid, ex_is_load, ex_wr_reg_n, ex_br_taken, mem_busy;

  logic        stall_if, stall_id, stall_ex, flush_id, flush_ex, trap_we, busy;
  logic [1:0]  pc_sel;
  logic [31:0] stall_cnt;

  logic        s_stall_if, s_stall_id, s_stall_ex, s_flush_id, s_flush_ex, s_trap_we, s_busy;
  logic [1:0]  s_pc_sel;
  logic [3:0]  s_stall_cnt;

  logic [8:0]  ctl;
  assign ctl = {stall_if, stall_id, stall_ex, flush_id, flush_ex, pc_sel, trap_we, busy};

  // {stall_if, stall_id, stall_ex, flush_id, flush_ex, pc_sel[1:0], trap_we, busy}
  localparam logic [8:0] C_IDLE   = 9'b000000000;
  localparam logic [8:0] C_LU     = 9'b110010000;
  localparam logic [8:0] C_BR     = 9'b000110100;
  localparam logic [8:0] C_DRN    = 9'b110010001;
  localparam logic [8:0] C_BSY_R  = 9'b111000000;
  localparam logic [8:0] C_BSY_T  = 9'b111000001;
  localparam logic [8:0] C_RED_E  = 9'b000111011;
  localparam logic [8:0] C_RED_M  = 9'b000111101;

  int vectors     = 0;
  int miscompares = 0;
  int twe_cnt     = 0;

  hazard_trap_ctrl #(.DRAIN_CYCLES(2), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_is_ecall(id_is_ecall), .id_is_mret(id_is_mret),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
    .ex_wr_reg_n(ex_wr_reg_n), .ex_br_taken(ex_br_taken), .mem_busy(mem_busy),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
    .flush_id(flush_id), .flush_ex(flush_ex), .pc_sel(pc_sel),
    .trap_we(trap_we), .busy(busy), .stall_cnt(stall_cnt)
  );

  hazard_trap_ctrl #(.DRAIN_CYCLES(2), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_is_ecall(id_is_ecall), .id_is_mret(id_is_mret),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
    .ex_wr_reg_n(ex_wr_reg_n), .ex_br_taken(ex_br_taken), .mem_busy(mem_busy),
    .stall_if(s_stall_if), .stall_id(s_stall_id), .stall_ex(s_stall_ex),
    .flush_id(s_flush_id), .flush_ex(s_flush_ex), .pc_sel(s_pc_sel),
    .trap_we(s_trap_we), .busy(s_busy), .stall_cnt(s_stall_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && trap_we) twe_cnt <= twe_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_is_ecall = 0; id_is_mret = 0;
    ex_valid = 0; ex_rd = 0; ex_is_load = 0; ex_wr_reg_n = 1; ex_br_taken = 0;
    mem_busy = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load(input logic [4:0] rd);
    ex_valid = 1; ex_is_load = 1; ex_wr_reg_n = 0; ex_rd = rd;
  endtask

  initial begin
    rst_n = 0;
    idle();
    tick(); tick();
    #3;
    chk("reset_ctl", {23'd0, ctl}, {23'd0, C_IDLE});
    chk("reset_cnt", stall_cnt, 32'd0);
    chk("reset_sat_cnt", {28'd0, s_stall_cnt}, 32'd0);
    rst_n = 1;
    tick();

    // load-use on rs1
    idle(); set_load(5'd5); id_valid = 1; id_use_rs1 = 1; id_rs1 = 5'd5; id_use_rs2 = 1; id_rs2 = 5'd7;
    #3; chk("lu_rs1_ctl", {23'd0, ctl}, {23'd0, C_LU});
    tick();
    ex_is_load = 0;
    #3; chk("lu_after_ctl", {23'd0, ctl}, {23'd0, C_IDLE});
    chk("lu_cnt", stall_cnt, 32'd1);
    tick();
    idle(); set_load(5'd0); id_valid = 1; id_use_rs1 = 1; id_rs1 = 5'd0;
    #3; chk("lu_rd0_ctl", {23'd0, ctl}, {23'd0, C_IDLE});
    tick();
    idle(); set_load(5'd5); ex_wr_reg_n = 1; id_valid = 1; id_use_rs1 = 1; id_rs1 = 5'd5;
    #3; chk("lu_nowr_ctl", {23'd0, ctl}, {23'd0, C_IDLE});
    tick();
    idle(); set_load(5'd5); id_valid = 1; id_use_rs1 = 1; id_rs1 = 5'd3; id_use_rs2 = 1; id_rs2 = 5'd5;
    #3; chk("lu_rs2_ctl", {23'd0, ctl}, {23'd0, C_LU});
    tick();
    ex_valid = 0;
    #3; chk("lu_exinv_ctl", {23'd0, ctl}, {23'd0, C_IDLE});
    chk("lu_rs2_cnt", stall_cnt, 32'd2);
    tick();

    // taken branch overrides ECALL in ID
    idle(); ex_valid = 1; ex_br_taken = 1; id_valid = 1; id_is_ecall = 1;
    #3; chk("br_ctl", {23'd0, ctl}, {23'd0, C_BR});
    tick();
    idle();
    #3; chk("br_after_ctl", {23'd0, ctl}, {23'd0, C_IDLE});
    chk("br_cnt", stall_cnt, 32'd2);
    tick();

    // ECALL, 1 drain cycle (branch flag in DRAIN is ignored)
    idle(); id_valid = 1; id_is_ecall = 1;
    #3; chk("ecall_det_ctl", {23'd0, ctl}, {23'd0, C_LU});
    tick();
    ex_br_taken = 1;
    #3; chk("ecall_drain_ctl", {23'd0, ctl}, {23'd0, C_DRN});
    tick();
    idle();
    #3; chk("ecall_redir_ctl", {23'd0, ctl}, {23'd0, C_RED_E});
    tick();
    #3; chk("ecall_done_ctl", {23'd0, ctl}, {23'd0, C_IDLE});
    chk("ecall_cnt", stall_cnt, 32'd4);
    chk("ecall_twe_cnt", twe_cnt, 32'd1);
    tick();

    // MRET with 3 busy cycles inside DRAIN
    idle(); id_valid = 1; id_is_mret = 1;
    #3; chk("mret_det_ctl", {23'd0, ctl}, {23'd0, C_LU});
    tick();
    mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      #3; chk("mret_busy_ctl", {23'd0, ctl}, {23'd0, C_BSY_T});
      tick();
    end
    mem_busy = 0;
    #3; chk("mret_drain_ctl", {23'd0, ctl}, {23'd0, C_DRN});
    tick();
    idle();
    #3; chk("mret_redir_ctl", {23'd0, ctl}, {23'd0, C_RED_M});
    tick();
    #3; chk("mret_done_ctl", {23'd0, ctl}, {23'd0, C_IDLE});
    chk("mret_cnt", stall_cnt, 32'd9);
    chk("mret_twe_cnt", twe_cnt, 32'd1);
    tick();

    // ECALL with mem_busy while in REDIRECT: redirect held, single trap_we
    idle(); id_valid = 1; id_is_ecall = 1;
    tick();
    tick();
    idle(); mem_busy = 1;
    #3; chk("ecbsy_hold_ctl", {23'd0, ctl}, {23'd0, C_BSY_T});
    tick();
    mem_busy = 0;
    #3; chk("ecbsy_redir_ctl", {23'd0, ctl}, {23'd0, C_RED_E});
    tick();
    #3; chk("ecbsy_done_ctl", {23'd0, ctl}, {23'd0, C_IDLE});
    chk("ecbsy_twe_cnt", twe_cnt, 32'd2);
    chk("ecbsy_cnt", stall_cnt, 32'd12);
    chk("ecbsy_sat_cnt", {28'd0, s_stall_cnt}, 32'd12);

    // saturation of the 4-bit counter under a long mem_busy
    mem_busy = 1;
    #3; chk("sat_busy_ctl", {23'd0, ctl}, {23'd0, C_BSY_R});
    for (int i = 0; i < 3; i++) tick();
    #3; chk("sat_reach_cnt", {28'd0, s_stall_cnt}, 32'd15);
    for (int i = 0; i < 17; i++) tick();
    #3; chk("sat_hold_cnt", {28'd0, s_stall_cnt}, 32'd15);
    chk("sat_wide_cnt", stall_cnt, 32'd32);
    mem_busy = 0;
    tick();

    // reset while in DRAIN
    idle(); id_valid = 1; id_is_ecall = 1;
    tick();
    #3; chk("rst_pre_busy", {31'd0, busy}, 32'd1);
    rst_n = 0; idle();
    #1; chk("rst_mid_ctl", {23'd0, ctl}, {23'd0, C_IDLE});
    chk("rst_mid_cnt", stall_cnt, 32'd0);
    chk("rst_mid_sat_cnt", {28'd0, s_stall_cnt}, 32'd0);
    tick();
    rst_n = 1;
    tick();
    #3; chk("rst_after_ctl", {23'd0, ctl}, {23'd0, C_IDLE});
    tick();
    #3; chk("rst_twe_cnt", twe_cnt, 32'd2);
    chk("rst_after_cnt", stall_cnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_trap_ctrl.md
Name: hazard_trap_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RV32I core, placed beside the decode stage.
- Consumes decode-side fields (rs1/rs2, ecall/mret flags) and EX-side status (load, rd, write enable, taken branch) plus the data-memory busy flag.
- Produces per-stage stall/flush controls and the PC-source select.
- Owns the multi-cycle ecall/mret drain-and-redirect sequence and a stall-cycle performance counter.

Parameters:
- DRAIN_CYCLES, 2: cycles spent draining instructions older than a trap before redirect; legal range 1..15.
- CNT_W, 32: width of the stall performance counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- id_valid  in  1  ID holds a real instruction
- id_rs1  in  5  ID source register 1
- id_rs2  in  5  ID source register 2
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- id_is_ecall  in  1  ID instruction is ECALL
- id_is_mret  in  1  ID instruction is MRET
- ex_valid  in  1  EX holds a real instruction
- ex_rd  in  5  EX destination register
- ex_is_load  in  1  EX instruction is a load
- ex_wr_reg_n  in  1  EX register write, 0 = write
- ex_br_taken  in  1  EX resolved a taken branch/JAL/JALR
- mem_busy  in  1  data memory not ready; whole pipe must hold
- stall_if  out  1  hold PC and IF/ID register
- stall_id  out  1  hold ID/EX inputs
- stall_ex  out  1  hold EX/MEM and later registers
- flush_id  out  1  IF/ID register loads a bubble
- flush_ex  out  1  ID/EX register loads a bubble
- pc_sel  out  2  00 = PC+4, 01 = branch target, 10 = mtvec, 11 = mepc
- trap_we  out  1  one-cycle pulse: write mepc/mcause for ECALL (mcause 11)
- busy  out  1  trap sequence in progress (state != RUN)
- stall_cnt  out  CNT_W  count of cycles with stall_if=1; saturates at all-ones

Behaviour:
- Outputs are combinational from state plus inputs; state, trap kind, drain counter and stall_cnt are registered.
- Reset (async, rst_n=0): state=RUN, drain_cnt=0, kind=0, stall_cnt=0. With idle inputs, all control outputs are 0 and pc_sel=00.
- States: RUN, DRAIN, REDIRECT.
- load_use = ex_valid & ex_is_load & !ex_wr_reg_n & ex_rd!=0 & id_valid & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- Priority in every state, highest first:
  1. mem_busy: stall_if=stall_id=stall_ex=1, all flushes 0, pc_sel=00, trap_we=0; state and drain_cnt frozen.
  2. ex_br_taken in RUN: pc_sel=01, flush_id=flush_ex=1. Any ecall/mret/load_use in ID is wrong-path and ignored; next state RUN.
  3. RUN with id_valid & (id_is_ecall | id_is_mret): stall_if=stall_id=1, flush_ex=1; kind:=mret?1:0; drain_cnt:=DRAIN_CYCLES-1; next DRAIN when DRAIN_CYCLES>1, else REDIRECT.
  4. RUN with load_use: stall_if=stall_id=1, flush_ex=1 for exactly one cycle; stay RUN.
- DRAIN: stall_if=stall_id=1, flush_ex=1; drain_cnt decrements each non-busy cycle; go to REDIRECT when drain_cnt==0 at a clock edge. ex_br_taken is ignored here (EX holds only bubbles).
- REDIRECT, one cycle: flush_id=flush_ex=1; pc_sel = kind?11:10; trap_we = !kind; next RUN.
- busy = (state != RUN).
- stall_cnt increments on every clock where stall_if=1 (mem_busy, load-use, DRAIN, trap detect); it holds at 2^CNT_W-1.
- Reset asserted mid-sequence returns to RUN immediately with no trap_we pulse.
- Simultaneous mem_busy and REDIRECT: REDIRECT is held; trap_we fires only on the first non-busy REDIRECT cycle, exactly once.

Test Plan:
- Reset mid-DRAIN (DRAIN_CYCLES=2, ecall detected, rst_n=0 one cycle later) -> state RUN, busy=0, stall_cnt=0, trap_we never pulses.
- Load-use: EX lw x5 (ex_is_load=1, ex_wr_reg_n=0, ex_rd=5), ID add using rs1=5 -> one cycle stall_if=stall_id=flush_ex=1, then all 0; stall_cnt=1. Same case with ex_rd=0 -> no stall.
- Branch vs ecall: ex_br_taken=1 with id_is_ecall=1 -> pc_sel=01, flush_id=flush_ex=1, busy stays 0, trap_we never asserts.
- ECALL, DRAIN_CYCLES=2 -> detect cycle stall; 1 DRAIN cycle; REDIRECT with pc_sel=10 and trap_we=1 for one cycle; busy=1 for 2 cycles; stall_cnt=2.
- MRET with mem_busy=1 for 3 cycles during DRAIN -> DRAIN extended by 3 cycles, stall_ex=1 for those cycles; REDIRECT pc_sel=11, trap_we=0.
- Saturation: CNT_W=4, hold mem_busy=1 for 20 cycles -> stall_cnt stops at 15.
